// File: rtl/pulse_stretch_pkg.sv
// pulse_stretch_pkg: FSM state encoding and counter sizing shared by the pulse stretcher files
package pulse_stretch_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_e;
  // Counter must hold max(high,gap)-1; never narrower than one bit.
  function automatic int cnt_width(input int h, input int g);
    int m;
    m = h > g ? h : g;
    return m < 2 ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/pulse_stretch_cycle_down_counter.sv
// cycle_down_counter: loadable saturating down counter with zero flag, timing the HIGH and GAP phases
//   clk, reset   : clock, asynchronous active-high reset
//   load_i       : load load_val_i (takes priority over dec_i)
//   load_val_i   : value loaded
//   dec_i        : decrement, holds at zero
//   zero_o       : counter is zero
module cycle_down_counter
  import pulse_stretch_pkg::*;
#(
  parameter int W = cnt_width(4, 2)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] value_q, value_d;
  always_comb value_d = load_i ? load_val_i : (dec_i && value_q != '0) ? value_q - W'(1) : value_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) value_q <= '0;
    else value_q <= value_d;
  assign zero_o = value_q == '0;
endmodule

// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle pulses into HIGH_CYCLES-wide level windows separated by GAP_CYCLES low clocks
//   clk, reset : clock, asynchronous active-high reset
//   pulse_in   : one pulse per high clock
//   level_out  : stretched level
//   busy       : FSM not idle
//   pending    : pulses queued while busy (saturates at QUEUE_DEPTH)
//   overflow   : sticky, a pulse was dropped
// Define PULSE_STRETCH_RETRIGGER_EN to make pulses during HIGH extend the current window instead of queueing.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int QUEUE_DEPTH = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pulse_in,
  output logic                             level_out,
  output logic                             busy,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] pending,
  output logic                             overflow
);
  localparam int PW = $clog2(QUEUE_DEPTH + 1);
  localparam int CW = cnt_width(HIGH_CYCLES, GAP_CYCLES);
`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif
  state_e state_q, state_d;
  logic [PW-1:0] pend_q, pend_d;
  logic ovf_q, ovf_d;
  logic ld, dec, zero, gap_end, deq, acc, full;
  logic [CW-1:0] ld_val;
  cycle_down_counter #(.W(CW)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ld),
    .load_val_i (ld_val),
    .dec_i      (dec),
    .zero_o     (zero)
  );
  assign gap_end = state_q == GAP && zero;
  assign deq     = gap_end && pend_q != '0;
  assign full    = pend_q == PW'(QUEUE_DEPTH);
  // A pulse on a GAP end with nothing queued restarts HIGH directly, so it never touches the queue.
  assign acc = pulse_in && state_q != IDLE && !(RETRIG && state_q == HIGH) && !(gap_end && pend_q == '0);
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    ld_val  = CW'(HIGH_CYCLES - 1);
    if (state_q == IDLE && pulse_in) begin
      state_d = HIGH;
      ld      = 1'b1;
    end else if (state_q == HIGH && RETRIG && pulse_in) begin
      ld = 1'b1;
    end else if (state_q == HIGH && zero) begin
      state_d = GAP;
      ld      = 1'b1;
      ld_val  = CW'(GAP_CYCLES - 1);
    end else if (gap_end) begin
      state_d = (deq || pulse_in) ? HIGH : IDLE;
      ld      = deq || pulse_in;
    end
    dec    = !ld && state_q != IDLE;
    pend_d = (acc && !deq) ? (full ? pend_q : pend_q + PW'(1)) : (!acc && deq) ? pend_q - PW'(1) : pend_q;
    ovf_d  = ovf_q || (acc && !deq && full);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  assign level_out = state_q == HIGH;
  assign busy      = state_q != IDLE;
  assign pending   = pend_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: directed-vector bench for pulse_stretch (HIGH=4, GAP=2, DEPTH=3)
module tb_pulse_stretch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pulse_in = 1'b0;
  logic level_out, busy, overflow;
  logic [1:0] pending;
  logic [1:0] pend_log [0:63];
  int vectors = 0;
  int fails = 0;

  pulse_stretch #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .QUEUE_DEPTH(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .pulse_in  (pulse_in),
    .level_out (level_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] win(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic do_reset();
    pulse_in = 1'b0;
    reset = 1'b1;
    #7;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Cycle k starts at the k-th rising edge after reset release; outputs sampled mid-cycle.
  task automatic run(input string name, input logic [63:0] p, input int n,
                     input logic [63:0] el, input logic [63:0] eb, input logic [63:0] eo);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1 pulse_in = p[k];
      @(negedge clk);
      pend_log[k] = pending;
      vectors += 3;
      if (level_out !== el[k]) begin
        fails++;
        $display("FAIL %s level_out cycle %0d: got %b want %b", name, k, level_out, el[k]);
      end
      if (busy !== eb[k]) begin
        fails++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, k, busy, eb[k]);
      end
      if (overflow !== eo[k]) begin
        fails++;
        $display("FAIL %s overflow cycle %0d: got %b want %b", name, k, overflow, eo[k]);
      end
    end
    pulse_in = 1'b0;
  endtask

  task automatic check_pend(input string name, input int k, input logic [1:0] exp);
    vectors++;
    if (pend_log[k] !== exp) begin
      fails++;
      $display("FAIL %s pending cycle %0d: got %0d want %0d", name, k, pend_log[k], exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    vectors += 4;
    if (level_out !== 1'b0) begin fails++; $display("FAIL reset level_out: got %b want 0", level_out); end
    if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", busy); end
    if (pending !== 2'd0) begin fails++; $display("FAIL reset pending: got %0d want 0", pending); end
    if (overflow !== 1'b0) begin fails++; $display("FAIL reset overflow: got %b want 0", overflow); end
  endtask

  task automatic test_single();
    do_reset();
    run("single", 64'd1 << 10, 20, win(11, 14), win(11, 16), '0);
    check_pend("single", 12, 2'd0);
  endtask

  task automatic test_three();
    logic [1:0] peak;
    do_reset();
    run("three", win(10, 12), 32, win(11, 14) | win(17, 20) | win(23, 26), win(11, 28), '0);
    peak = '0;
    for (int k = 0; k < 32; k++) if (pend_log[k] > peak) peak = pend_log[k];
    vectors++;
    if (peak !== 2'd2) begin fails++; $display("FAIL three pending peak: got %0d want 2", peak); end
    check_pend("three", 13, 2'd2);
    check_pend("three", 17, 2'd1);
    check_pend("three", 23, 2'd0);
  endtask

  task automatic test_overflow();
    do_reset();
    run("overflow", win(10, 14), 40, win(11, 14) | win(17, 20) | win(23, 26) | win(29, 32),
        win(11, 34), win(15, 63));
    check_pend("overflow", 14, 2'd3);
    check_pend("overflow", 39, 2'd0);
  endtask

  task automatic test_async_reset();
    do_reset();
    run("async_reset", win(10, 14), 19, win(11, 14) | win(17, 18), win(11, 18), win(15, 63));
    check_pend("async_reset", 18, 2'd2);
    #3 reset = 1'b1;
    #1;
    vectors += 4;
    if (level_out !== 1'b0) begin fails++; $display("FAIL async_reset level_out: got %b want 0", level_out); end
    if (busy !== 1'b0) begin fails++; $display("FAIL async_reset busy: got %b want 0", busy); end
    if (pending !== 2'd0) begin fails++; $display("FAIL async_reset pending: got %0d want 0", pending); end
    if (overflow !== 1'b0) begin fails++; $display("FAIL async_reset overflow: got %b want 0", overflow); end
  endtask

  task automatic test_retrigger();
    logic [63:0] p;
    p = (64'd1 << 10) | (64'd1 << 12);
    do_reset();
`ifdef PULSE_STRETCH_RETRIGGER_EN
    run("retrigger", p, 24, win(11, 16), win(11, 18), '0);
`else
    run("retrigger", p, 24, win(11, 14) | win(17, 20), win(11, 22), '0);
`endif
  endtask

  task automatic test_full_dequeue();
    do_reset();
    run("full_dequeue", win(10, 13) | (64'd1 << 16), 44,
        win(11, 14) | win(17, 20) | win(23, 26) | win(29, 32) | win(35, 38), win(11, 40), '0);
    check_pend("full_dequeue", 14, 2'd3);
    check_pend("full_dequeue", 16, 2'd3);
    check_pend("full_dequeue", 17, 2'd3);
    check_pend("full_dequeue", 23, 2'd2);
  endtask

  task automatic test_gap_chain();
    do_reset();
    run("gap_chain", (64'd1 << 10) | (64'd1 << 16), 26, win(11, 14) | win(17, 20), win(11, 22), '0);
    check_pend("gap_chain", 17, 2'd0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_retrigger();
    test_gap_chain();
`ifndef PULSE_STRETCH_RETRIGGER_EN
    test_three();
    test_overflow();
    test_async_reset();
    test_full_dequeue();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
